// File: rtl/multi_project_io_mux.sv
// rtl/multi_project_io_mux.sv - shares Caravel pads and one LA bank between NUM_PROJ projects
// Requests are synchronised and priority-resolved, and every switch tristates the pads for a guard interval.
module multi_project_io_mux #(
  parameter int NUM_PROJ     = 4,
  parameter int IO_W         = 38,
  parameter int LA_W         = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 4,
  localparam int SEL_W       = $clog2(NUM_PROJ)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic [NUM_PROJ-1:0]      active_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
  input  logic [NUM_PROJ*LA_W-1:0] proj_la_out_i,
  output logic [NUM_PROJ-1:0]      proj_en_o,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb,
  output logic [LA_W-1:0]          la_data_out,
  output logic [SEL_W-1:0]         sel_o,
  output logic                     busy_o,
  output logic                     multi_err_o,
  output logic [7:0]               switch_cnt_o
);

  typedef enum logic [1:0] {IDLE, GUARD, RUN} state_t;

  localparam logic [7:0] RELOAD = 8'(GUARD_CYCLES - 1);

  logic [NUM_PROJ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PROJ-1:0] act_s;
  logic                req_valid;
  logic [SEL_W-1:0]    req_idx;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    target_q, target_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_PROJ-1:0] en_q, en_d;
  logic [7:0]          swc_q, swc_d;
  logic                merr_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      merr_q <= 1'b0;
    end else begin
      sync_q[0] <= active_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      merr_q <= |(act_s & (act_s - NUM_PROJ'(1)));
    end
  end

  assign act_s     = sync_q[SYNC_STAGES-1];
  assign req_valid = |act_s;

  // Fixed priority: scanning downward leaves the lowest set index.
  always_comb begin
    req_idx = '0;
    for (int p = NUM_PROJ - 1; p >= 0; p--) begin
      if (act_s[p]) req_idx = SEL_W'(p);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      swc_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      swc_q    <= swc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    en_d     = '0;
    swc_d    = swc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = GUARD;
          target_d = req_idx;
          cnt_d    = RELOAD;
        end
      end
      GUARD: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else if (req_idx != target_q) begin
          target_d = req_idx;
          cnt_d    = RELOAD;
        end else if (cnt_q == 8'd0) begin
          state_d = RUN;
          sel_d   = target_q;
          en_d    = NUM_PROJ'(1) << target_q;
          if (swc_q != 8'hFF) swc_d = swc_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RUN: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else if (req_idx != sel_q) begin
          state_d  = GUARD;
          target_d = req_idx;
          cnt_d    = RELOAD;
        end else begin
          en_d = en_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pads follow the registered state only, so an async reset tristates them at once.
  always_comb begin
    io_out      = '0;
    io_oeb      = '1;
    la_data_out = '0;
    if (state_q == RUN) begin
      io_out      = proj_io_out_i[sel_q*IO_W +: IO_W];
      io_oeb      = proj_io_oeb_i[sel_q*IO_W +: IO_W];
      la_data_out = proj_la_out_i[sel_q*LA_W +: LA_W];
    end
  end

  assign proj_en_o    = en_q;
  assign sel_o        = sel_q;
  assign busy_o       = (state_q == GUARD);
  assign multi_err_o  = merr_q;
  assign switch_cnt_o = swc_q;

endmodule

// File: doc/multi_project_io_mux.md
Name: multi_project_io_mux

Overview:
- Parametrised successor to the single-project hookup in user_project_wrapper.
- Shares the Caravel IO pads and one 32-bit logic-analyser output bank between NUM_PROJ wrapped projects.
- Selection is driven by the per-project active bits from la_data_in. The block synchronises them and resolves multi-hot requests by priority.
- Every project switch passes through a guard interval: all pads are tristated and all projects disabled, so no two projects ever drive the pads in the same cycle.

Parameters:
- NUM_PROJ, 4, number of wrapped projects (2..32).
- IO_W, 38, pad count (`MPRJ_IO_PADS).
- LA_W, 32, logic-analyser output bits per project.
- SYNC_STAGES, 2, flops in the active-bit synchroniser (>=2).
- GUARD_CYCLES, 4, tristate cycles on every switch (1..255).

Ports:
- wb_clk_i  input  1  single clock.
- wb_rst_n  input  1  reset; asynchronous assert, active-low.
- active_i  input  NUM_PROJ  raw project enables from la_data_in; asynchronous to the FSM.
- proj_io_out_i  input  NUM_PROJ*IO_W  per-project io_out, project p at [p*IO_W +: IO_W].
- proj_io_oeb_i  input  NUM_PROJ*IO_W  per-project io_oeb, same packing.
- proj_la_out_i  input  NUM_PROJ*LA_W  per-project la_data_out, same packing.
- proj_en_o  output  NUM_PROJ  registered one-hot project enable.
- io_out  output  IO_W  pad outputs.
- io_oeb  output  IO_W  pad output-enable bar.
- la_data_out  output  LA_W  logic-analyser bank.
- sel_o  output  $clog2(NUM_PROJ)  index of the running project.
- busy_o  output  1  high in GUARD.
- multi_err_o  output  1  registered; high while the synchronised active vector has more than one bit set.
- switch_cnt_o  output  8  saturating count of RUN entries.

Behaviour:
Reset (async, wb_rst_n=0):
- State IDLE, synchroniser cleared, proj_en_o=0, sel_o=0, busy_o=0, multi_err_o=0, switch_cnt_o=0.
- io_oeb all 1, io_out=0, la_data_out=0.

Synchroniser and request decode:
- active_i passes through SYNC_STAGES flops; the last stage is act_s.
- req_valid = |act_s.
- req_idx = lowest set bit of act_s (fixed priority, project 0 highest).

FSM states: IDLE, GUARD, RUN.
- IDLE: if req_valid, go to GUARD with target<=req_idx and cnt<=GUARD_CYCLES-1.
- GUARD:
  - !req_valid: go to IDLE.
  - req_idx!=target: retarget, target<=req_idx, cnt reloads to GUARD_CYCLES-1.
  - cnt==0: go to RUN, sel_o<=target, proj_en_o<=one-hot(target), switch_cnt_o++ (saturates at 255).
  - otherwise: cnt--.
- RUN:
  - !req_valid: go to IDLE.
  - req_idx!=sel_o: go to GUARD, target<=req_idx, cnt reload.
  - otherwise: hold.
- proj_en_o is registered: it is 0 in every cycle the state is not RUN and clears on the same edge that leaves RUN.

Output mux (combinational from registered state):
- In RUN: io_out, io_oeb and la_data_out are the sel_o slices of the project inputs, with zero added latency.
- Otherwise: io_oeb all 1, io_out=0, la_data_out=0.

Latency:
- Input stable before edge 1 → act_s updates at edge SYNC_STAGES.
- GUARD is entered at edge SYNC_STAGES+1.
- RUN is entered at edge SYNC_STAGES+1+GUARD_CYCLES (defaults: edge 7).

Boundary conditions:
- Multi-hot: the lowest index wins and multi_err_o is high. Raising a higher-index bit while a lower one runs causes no switch.
- Dropping the running bit while another bit remains forces GUARD toward the new lowest index; the block never goes straight from RUN to RUN.
- Glitch shorter than one clock on active_i: tolerated only to the extent the synchroniser filters it. Any change of act_s triggers a full guard interval.
- GUARD_CYCLES=1: exactly one tristate cycle.
- Reset mid-GUARD or mid-RUN: immediate return to the reset values; pads tristate asynchronously.

Test Plan:
- Reset, then active_i=4'b0100 → RUN at edge 7 with sel_o=2 and proj_en_o=4'b0100. Pads carry project 2's values (e.g. io_out=38'h2A5A5A5A5A). busy_o is high for exactly 4 cycles. switch_cnt_o=1.
- Running project 2, change active_i to 4'b0001 → io_oeb is all 1 and proj_en_o=0 for 4+ cycles, then sel_o=0. Pads are never driven by project 0 and project 2 in the same cycle.
- active_i=4'b1010 → sel_o=1, multi_err_o=1. Then active_i=4'b1000 → guard, then sel_o=3, multi_err_o=0.
- Retarget mid-GUARD: 4'b0010 then 4'b0100 after 2 guard cycles → counter reloads; RUN with sel_o=2 comes a full 4 cycles after the retarget is synchronised.
- Assert wb_rst_n=0 mid-RUN → io_oeb is all 1 and proj_en_o=0 without waiting for a clock edge. After release with active_i still set, the full 7-edge sequence repeats.
- 300 switches alternating 0↔1 → switch_cnt_o saturates at 255.
